wisc_perf_counters: RTL

Synthesizable, parametrised performance-counter unit for the WISC pipeline. It succeeds the simulation-only trace/stat counters and keeps event tallies in hardware. NUM_EVENTS single-bit event strobes (cache req/hit, retired inst, mem rd/wr, stalls) feed independent counters, plus one cycle counter. Adds a warm-up ignore window, a freeze on Halt, a synchronous clear, selectable saturate/wrap overflow, and a registered read-out port that the WriteBack-stage debug logic or the bench can sample after the halt.

---
 rtl/wisc_perf_pkg.sv | 19 +
 rtl/wisc_perf_counter.sv | 32 +++
 rtl/wisc_perf_counters.sv | 102 ++++++++++
 3 files changed

// File: rtl/wisc_perf_pkg.sv
// Shared types and event channel indices for the WISC performance-counter unit.
package wisc_perf_pkg;

    typedef enum logic [1:0] {
        WARM     = 2'd0,
        COUNTING = 2'd1,
        FROZEN   = 2'd2
    } perf_state_e;

    localparam int EV_ICACHE_REQ = 0;
    localparam int EV_ICACHE_HIT = 1;
    localparam int EV_DCACHE_REQ = 2;
    localparam int EV_DCACHE_HIT = 3;
    localparam int EV_INST_RET   = 4;
    localparam int EV_MEM_RD     = 5;
    localparam int EV_MEM_WR     = 6;
    localparam int EV_STALL      = 7;

endpackage

// File: rtl/wisc_perf_counter.sv
// One event counter with a sticky overflow flag; clear beats increment, hold masks it.
module wisc_perf_counter #(
    parameter int CNT_WIDTH = 32,
    parameter bit SATURATE  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clr,
    input  logic                 hold,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 ovf
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (inc && !hold) begin
            if (&cnt) begin
                ovf <= 1'b1;
                cnt <= SATURATE ? cnt : '0;
            end else begin
                cnt <= cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/wisc_perf_counters.sv
// Performance-counter unit: NUM_EVENTS event counters plus a cycle counter,
// gated by a warm-up / counting / frozen FSM, with a registered read port.
module wisc_perf_counters
    import wisc_perf_pkg::*;
#(
    parameter int NUM_EVENTS    = 8,
    parameter int CNT_WIDTH     = 32,
    parameter bit SATURATE      = 1'b1,
    parameter int WARMUP_CYCLES = 4,
    parameter int SEL_WIDTH     = $clog2(NUM_EVENTS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_EVENTS-1:0] event_vec,
    input  logic                  halt,
    input  logic                  clear,
    input  logic                  rd_req,
    input  logic [SEL_WIDTH-1:0]  rd_sel,
    output logic [CNT_WIDTH-1:0]  rd_data,
    output logic                  rd_valid,
    output logic [NUM_EVENTS:0]   ovf_flags,
    output logic                  frozen,
    output logic                  counting
);

    localparam int NCNT = NUM_EVENTS + 1;
    localparam int WW   = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES + 1) : 1;
    localparam perf_state_e RST_STATE = (WARMUP_CYCLES == 0) ? COUNTING : WARM;

    perf_state_e                     state, state_nxt;
    logic [WW-1:0]                   warm_cnt;
    logic                            warm_done;
    logic [NCNT-1:0]                 inc_vec;
    logic [NCNT-1:0][CNT_WIDTH-1:0]  cnt_arr;
    logic [CNT_WIDTH-1:0]            rd_mux;

    // warm_cnt holds the number of WARM cycles already spent
    assign warm_done = (32'(warm_cnt) + 32'd1 >= 32'(WARMUP_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RST_STATE;
            warm_cnt <= '0;
        end else begin
            state    <= state_nxt;
            warm_cnt <= (state == WARM) ? warm_cnt + WW'(1) : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WARM:     if (halt) state_nxt = FROZEN;
                      else if (warm_done) state_nxt = COUNTING;
            COUNTING: if (halt) state_nxt = FROZEN;
            FROZEN:   state_nxt = FROZEN;
            default:  state_nxt = RST_STATE;
        endcase
        if (clear) state_nxt = halt ? FROZEN : COUNTING;
    end

    always_comb begin
        counting = (state == COUNTING);
        frozen   = (state == FROZEN);
    end

    // The cycle counter sits in the top slot, above the event channels
    assign inc_vec = {1'b1, event_vec};

    for (genvar g = 0; g < NCNT; g++) begin : g_cnt
        wisc_perf_counter #(
            .CNT_WIDTH (CNT_WIDTH),
            .SATURATE  (SATURATE)
        ) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .inc  (inc_vec[g]),
            .clr  (clear),
            .hold (!counting),
            .cnt  (cnt_arr[g]),
            .ovf  (ovf_flags[g])
        );
    end

    // Out-of-range selects fall through to zero
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NCNT; i++)
            if (rd_sel == SEL_WIDTH'(i)) rd_mux = cnt_arr[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) rd_data <= rd_mux;
        end
    end

endmodule
